// File: rtl/pin_sampler_if.sv
// RAM port-B write bus between the pin sampler and the shared dual-port RAM.
interface pin_sampler_if #(
  parameter int unsigned ADDR_W = 21
);
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data_out;
  logic              ram_wr;
  logic              ram_en;

  modport master (output ram_addr, output ram_data_out, output ram_wr, output ram_en);
  modport slave  (input  ram_addr, input  ram_data_out, input  ram_wr, input  ram_en);
endinterface

// File: rtl/pin_sampler.sv
// Samples 16 pins at a programmable period into a RAM ring buffer, following
// each sample with a status/pointer word the MCU can poll.
module pin_sampler #(
  parameter int unsigned       ADDR_W    = 21,
  parameter logic [ADDR_W-1:0] BUF_BASE  = ADDR_W'(21'h001000),
  parameter int unsigned       BUF_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] PTR_ADDR  = ADDR_W'(21'h000FFF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         pin_in,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [15:0]         divider,
  pin_sampler_if.master       ram,
  output logic                busy,
  output logic                wrapped,
  output logic                done
);

  localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned PER_W = 16;
  localparam int unsigned DAT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_PTR, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [DAT_W-1:0]   sync1_q, sync1_d, pin_s_q, pin_s_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wrapped_q, wrapped_d, done_q, done_d, busy_q, busy_d;
  logic [PER_W-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic               cont_q, cont_d, stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DAT_W-1:0]   ram_data_q, ram_data_d;
  logic               ram_wr_q, ram_wr_d;

  logic               start_ok, last, wrap_nx, halt;
  logic [IDX_W-1:0]   idx_inc;

  assign start_ok = start & ~stop;
  assign last     = (idx_q == IDX_W'(BUF_DEPTH - 1));
  assign idx_inc  = idx_q + IDX_W'(1);
  assign wrap_nx  = wrapped_q | last;
  assign halt     = stop_pend_q | stop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_ok) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_PTR;
      S_PTR: begin
        if (halt)                  state_d = S_IDLE;
        else if (!cont_q && last)  state_d = S_IDLE;
        else if (period_q == PER_W'(2)) state_d = S_SAMPLE;
        else                       state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop)                  state_d = S_IDLE;
        else if (cnt_q == '0)      state_d = S_SAMPLE;
      end
      default:                     state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sync1_d     = pin_in;
    pin_s_d     = sync1_q;
    idx_d       = idx_q;
    wrapped_d   = wrapped_q;
    done_d      = done_q;
    period_d    = period_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    stop_pend_d = (state_q == S_SAMPLE) & stop;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          period_d  = (divider < PER_W'(2)) ? PER_W'(2) : divider;
          cont_d    = continuous;
          idx_d     = '0;
          wrapped_d = 1'b0;
          done_d    = 1'b0;
        end
      end
      S_PTR: begin
        idx_d     = idx_inc;
        wrapped_d = wrap_nx;
        cnt_d     = period_q - PER_W'(3);
        if (!halt && !cont_q && last) done_d = 1'b1;
      end
      S_WAIT: if (cnt_q != '0) cnt_d = cnt_q - PER_W'(1);
      default: ;
    endcase

    busy_d   = (state_d != S_IDLE);
    ram_wr_d = (state_d == S_SAMPLE) || (state_d == S_PTR);

    // Address/data are presented the cycle the write is issued; idx_d is the slot being filled
    if (state_d == S_SAMPLE) begin
      ram_addr_d = BUF_BASE + ADDR_W'(idx_d);
      ram_data_d = pin_s_q;
    end else if (state_d == S_PTR) begin
      ram_addr_d = PTR_ADDR;
      ram_data_d = {wrap_nx, 15'(idx_inc)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      pin_s_q     <= '0;
      idx_q       <= '0;
      wrapped_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      period_q    <= PER_W'(2);
      cont_q      <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      pin_s_q     <= pin_s_d;
      idx_q       <= idx_d;
      wrapped_q   <= wrapped_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      period_q    <= period_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign ram.ram_addr     = ram_addr_q;
  assign ram.ram_data_out = ram_data_q;
  assign ram.ram_wr       = ram_wr_q;
  assign ram.ram_en       = ram_wr_q;
  assign busy             = busy_q;
  assign wrapped          = wrapped_q;
  assign done             = done_q;

endmodule

// File: tb/tb_pin_sampler.sv
// Randomized scoreboard bench for pin_sampler: a schedule-level model predicts every RAM write.
module tb_pin_sampler;

  localparam int DEPTH  = 8;
  localparam int BASE   = 'h1000;
  localparam int PTRA   = 'hFFF;
  localparam int NONE   = 32'h3fff_ffff;
  localparam int PLAN_N = 8192;

  typedef struct {
    int          cyc;
    logic [20:0] addr;
    logic [15:0] data;
    logic        wrp;
  } wr_t;

  logic        clk, reset, start, stop, continuous, busy, wrapped, done;
  logic [15:0] pin_in, divider;
  int          cyc;
  int          n_cmp, n_bad;
  logic [15:0] pin_plan [PLAN_N];
  wr_t         sb [$];

  pin_sampler_if #(.ADDR_W(21)) ram_if ();

  pin_sampler #(
    .ADDR_W(21), .BUF_BASE(21'h001000), .BUF_DEPTH(DEPTH), .PTR_ADDR(21'h000FFF)
  ) dut (
    .clk(clk), .reset(reset), .pin_in(pin_in), .start(start), .stop(stop),
    .continuous(continuous), .divider(divider), .ram(ram_if.master),
    .busy(busy), .wrapped(wrapped), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pins follow a pre-planned per-cycle sequence so the model can look them up
  always @(posedge clk) begin
    #1;
    pin_in = pin_plan[cyc % PLAN_N];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every issued write must match the head of the scoreboard
  always @(negedge clk) begin
    wr_t e;
    n_cmp++;
    if (ram_if.ram_en !== ram_if.ram_wr) begin
      n_bad++;
      $display("FAIL en_eq_wr cyc=%0d en=%b wr=%b", cyc, ram_if.ram_en, ram_if.ram_wr);
    end
    if (ram_if.ram_wr === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, ram_if.ram_addr, ram_if.ram_data_out);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || ram_if.ram_addr !== e.addr || ram_if.ram_data_out !== e.data || wrapped !== e.wrp) begin
          n_bad++;
          $display("FAIL write act cyc=%0d addr=%h data=%h wrapped=%b exp cyc=%0d addr=%h data=%h wrapped=%b",
                   cyc, ram_if.ram_addr, ram_if.ram_data_out, wrapped, e.cyc, e.addr, e.data, e.wrp);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(ram_if.ram_addr), 32'(0));
    chk({tag, "_data"}, 32'(ram_if.ram_data_out), 32'(0));
    chk({tag, "_wr"},   32'(ram_if.ram_wr), 32'(0));
    chk({tag, "_en"},   32'(ram_if.ram_en), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_wrap"}, 32'(wrapped), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // One capture: offsets are relative to the start cycle, negative means unused
  task automatic run(input int div, input bit cont, input int stop_off, input int rst_off,
                     input int xs_off, input bit step);
    int ns, p, t, idx, end_c, stop_a, rst_a, xs_a, abort_a;
    bit w, last, done_e, pend;
    wr_t e;
    ns      = cyc + 4;
    p       = (div < 2) ? 2 : div;
    stop_a  = (stop_off >= 0) ? ns + stop_off : NONE;
    rst_a   = (rst_off  >= 0) ? ns + rst_off  : NONE;
    xs_a    = (xs_off   >= 0) ? ns + xs_off   : NONE;
    abort_a = (stop_a < rst_a) ? stop_a : rst_a;
    if (step)
      for (int k = 0; k < DEPTH; k++)
        for (int j = 0; j < p; j++) pin_plan[(ns - 2 + k * p + j) % PLAN_N] = 16'(k + 1);

    idx = 0; w = 1'b0; done_e = 1'b0; t = ns + 1; end_c = t + 2;
    for (int k = 0; k < 400; k++) begin
      last   = (idx == DEPTH - 1);
      e.cyc  = t;     e.addr = 21'(BASE + idx); e.data = pin_plan[(t - 3) % PLAN_N]; e.wrp = w;
      sb.push_back(e);
      e.cyc  = t + 1; e.addr = 21'(PTRA); e.data = {w | last, 15'((idx + 1) % DEPTH)}; e.wrp = w;
      sb.push_back(e);
      pend   = (stop_a == t) || (stop_a == t + 1);
      idx    = (idx + 1) % DEPTH;
      w      = w | last;
      end_c  = t + 2;
      if (pend) break;
      if (!cont && last) begin done_e = 1'b1; break; end
      if (abort_a >= t + 2 && abort_a <= t + p - 1) begin end_c = abort_a + 1; break; end
      t += p;
    end
    if (rst_a != NONE) w = 1'b0;
    if (xs_a <= ns || xs_a >= end_c) xs_a = NONE;

    forever begin
      @(posedge clk); #1;
      if (cyc == rst_a + 1) reset = 1'b1;
      start      = (cyc == ns) || (cyc == xs_a);
      stop       = (cyc == stop_a);
      divider    = (cyc == ns) ? 16'(div) : 16'($urandom);
      continuous = (cyc == ns) ? cont : 1'($urandom);
      if (cyc == rst_a) begin
        #1 reset = 1'b0;
        #1 chk_reset_vals("async_reset");
      end else #2;
      if (cyc == ns + 1) begin
        chk("busy_after_start", 32'(busy), 32'(1));
        chk("done_cleared", 32'(done), 32'(0));
      end
      if (cyc == end_c - 1 && rst_a == NONE) chk("busy_before_end", 32'(busy), 32'(1));
      if (cyc == end_c) begin
        chk("busy_end", 32'(busy), 32'(0));
        chk("done_end", 32'(done), 32'(done_e));
        chk("wrapped_end", 32'(wrapped), 32'(w));
        break;
      end
    end
    stop = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  task automatic start_stop_idle();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1; divider = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("startstop_busy", 32'(busy), 32'(0));
    chk("startstop_nowr", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, so, xo;
    bit c;
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < PLAN_N; i++) pin_plan[i] = 16'($urandom);
    reset = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; divider = '0; pin_in = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(4, 1'b0, -1, -1, -1, 1'b1);          // one-shot, stepping pins
    run(0, 1'b1, 22, -1, -1, 1'b0);          // continuous P=2, wraps
    run(5, 1'b0, 13, -1, -1, 1'b0);          // stop in WAIT after 3rd sample
    run(3, 1'b0, 7, -1, -1, 1'b0);           // stop with SAMPLE write
    start_stop_idle();
    run(6, 1'b1, -1, 22, -1, 1'b0);          // reset mid-WAIT
    run(3, 1'b0, -1, -1, -1, 1'b0);          // restart from entry 0
    run(7, 1'b0, -1, -1, 10, 1'b0);          // start while busy

    for (int i = 0; i < 14; i++) begin
      d  = int'($urandom_range(0, 9));
      c  = 1'($urandom_range(0, 1));
      xo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : -1;
      if (c)                               so = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 1) == 1)  so = int'($urandom_range(1, 8 * ((d < 2) ? 2 : d) + 2));
      else                                 so = -1;
      run(d, c, so, -1, xo, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_sampler.md
# pin_sampler

Capture engine for the FPGA-side port of the shared dual-port RAM, carrying data the opposite way to the command path. The command path reads configuration words and drives `pin_out`. This block instead samples 16 input pins at a programmable rate and writes each sample word into a ring buffer in shared RAM. After each sample it also writes a status/pointer word, so the MCU can poll progress and read samples back over EBI.

## Interface
Parameters:
- `ADDR_W`, 21: RAM address width.
- `BUF_BASE`, 21'h001000: word address of buffer entry 0.
- `BUF_DEPTH`, 1024: buffer entries; power of two, 2..32768.
- `PTR_ADDR`, 21'h000FFF: word address of the status/pointer word.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low.
- `pin_in`, in, 16: asynchronous input pins.
- `start`, in, 1: one-cycle start request.
- `stop`, in, 1: one-cycle abort request.
- `continuous`, in, 1: 1 = wrap forever; 0 = one-shot (stop when buffer full). Sampled at start.
- `divider`, in, 16: sample period in clocks. Values 0, 1 and 2 all mean 2. Sampled at start.
- `ram_addr`, out, ADDR_W: RAM port-B address.
- `ram_data_out`, out, 16: RAM write data.
- `ram_wr`, out, 1: RAM write enable.
- `ram_en`, out, 1: RAM port enable.
- `busy`, out, 1: capture active.
- `wrapped`, out, 1: write index has wrapped to 0 at least once since start.
- `done`, out, 1: one-shot capture completed. Held until the next accepted start.

## Operation
- Input sync: two-flop synchronizer on `pin_in`. The value written is the synchronizer output (`pin_s`).
- Index `idx`: log2(BUF_DEPTH) bits; wraps modulo BUF_DEPTH.
- Period `P`: P = max(divider, 2), latched into a period register at start.
- IDLE:
  - `start`=1 and `stop`=0: latch P and `continuous`; clear `idx`, `wrapped`, `done`; set `busy`; go to SAMPLE.
  - `start` and `stop` together: `stop` wins; stay in IDLE.
- SAMPLE (one cycle):
  - ram_en=1, ram_wr=1, ram_addr=BUF_BASE+idx, ram_data_out=pin_s.
  - Go to PTR.
- PTR (one cycle):
  - Write to PTR_ADDR. Data: bit15 = wrapped', bits[14:0] = (idx+1) mod BUF_DEPTH. wrapped' is `wrapped` OR (idx+1 == BUF_DEPTH).
  - Update `idx` and `wrapped` to those values.
  - Then, in priority order:
    - stop pending → IDLE.
    - one-shot and idx+1 == BUF_DEPTH → IDLE with done=1.
    - P == 2 → SAMPLE.
    - otherwise → WAIT with down-counter loaded to P-3.
- WAIT:
  - ram_en=0, ram_wr=0.
  - `stop` → IDLE immediately.
  - Counter == 0 → SAMPLE; else decrement.
- Stop handling:
  - `stop` during SAMPLE is remembered as pending. The PTR write still completes, so the pointer word always matches the written samples.
  - `stop` in PTR takes effect at the end of PTR.
  - `start` while busy is ignored.
- `busy` = 1 in SAMPLE, PTR and WAIT; 0 in IDLE.
- Reset asserted at any point: return to IDLE immediately. No further RAM access. A write being issued in that cycle is not completed by this block.

## Timing
- Reset values:
  - ram_addr=0, ram_data_out=0, ram_wr=0, ram_en=0.
  - busy=0, wrapped=0, done=0.
  - Synchronizer flops=0, idx=0, state IDLE.
- All outputs are registered.
- `start` accepted in cycle N:
  - busy=1 from N+1.
  - First sample write in N+1; first pointer write in N+2.
- Sample writes occur exactly P cycles apart; pointer writes trail each sample write by 1 cycle.
- Pin-to-write latency: a pin change is stored by the sample write at least 2 cycles later (synchronizer depth). The write in cycle N+1 carries the synchronizer output registered in N.
- ram_en equals ram_wr in every cycle. Writes only, never reads.
- One-shot end, final PTR write in cycle M: busy=0 and done=1 from M+1.
- `stop` in WAIT at cycle M: busy=0 from M+1; no further writes.

## Test plan
- One-shot, BUF_DEPTH=8, divider=4, pin_in stepping 0x0001..0x0008 once per sample:
  - 8 sample writes at BUF_BASE+0..7, 4 cycles apart, data 0x0001..0x0008.
  - Pointer words 0x0001..0x0007, then 0x8000.
  - done=1 and busy=0 after the last pointer write.
- Continuous, BUF_DEPTH=8, divider=0:
  - Writes alternate SAMPLE/PTR every cycle with P=2.
  - 9th sample goes to BUF_BASE+0 with wrapped=1; pointer word 0x8001.
- Stop pulsed in WAIT after sample 3:
  - No further writes; busy drops the next cycle.
  - Last pointer word 0x0003; done stays 0.
- Stop asserted the same cycle as a SAMPLE write:
  - The PTR write still occurs, then IDLE.
  - start and stop together in IDLE → no writes.
- Reset (low) mid-WAIT during continuous capture:
  - All outputs return to their reset values asynchronously.
  - A subsequent start begins again at BUF_BASE+0.
- start pulsed while busy:
  - Ignored; idx continues, period unchanged; changing `divider` mid-capture has no effect.
